sys_arr_result_collector: RTL and testbench
===========================================

// Module: sys_arr_result_collector
// PURPOSE
//   Receive end of the systolic array's bottom-row output. Accepts column-skewed
//   16-bit MAC sums (column j valid one cycle after column j-1), deskews them into
//   whole result rows and buffers them in a FIFO. Presents the rows to the output
//   buffer writer over a valid/ready stream. The array cannot stall, so the FIFO is
//   the only elasticity; loss is flagged, never back-pressured.
// PARAMETERS
//   WIDTH_HEIGHT  2   array columns; one 16-bit sum lane per column
//   FIFO_DEPTH    4   result rows buffered; power of 2, >= 2
// PORTS
//   clk        in   1                  clock, all logic on rising edge
//   rst_n      in   1                  async active-low reset
//   start      in   1                  pulse: begin collecting num_rows rows
//   num_rows   in   8                  rows to collect, sampled on start
//   maccin     in   16*WIDTH_HEIGHT    array bottom-row sums, column 0 in LSBs
//   colvalid   in   WIDTH_HEIGHT       per-column sum valid, skewed +1 cycle/column
//   out_data   out  16*WIDTH_HEIGHT    deskewed result row, column 0 in LSBs
//   out_row    out  8                  index of the row on out_data (0-based)
//   out_valid  out  1                  out_data/out_row valid
//   out_ready  in   1                  consumer accepts when valid&&ready
//   busy       out  1                  high in COLLECT or DRAIN
//   done       out  1                  1-cycle pulse after the last row handshakes
//   overflow   out  1                  sticky: row dropped, FIFO full
//   skew_err   out  1                  sticky: partially valid aligned row seen
// BEHAVIOUR
//   Reset: all outputs 0; FIFO empty; state IDLE; counters 0; deskew regs 0.
//   Deskew: column j sum and valid pass through WIDTH_HEIGHT-1-j register stages.
//     Column WIDTH_HEIGHT-1 has 0 stages. Aligned row exists when all delayed valids = 1.
//   Some, but not all, delayed valids = 1 -> skew_err set. That row is discarded.
//   Latency: aligned in the cycle column WIDTH_HEIGHT-1 is valid. The FIFO write is
//     registered, so out_valid rises the next cycle when the FIFO was empty.
//   States:
//     IDLE    - start with num_rows!=0: latch num_rows, clear counters and
//               sticky flags, go to COLLECT.
//             - start with num_rows==0: assert done next cycle, stay IDLE.
//             - aligned rows in IDLE are ignored.
//     COLLECT - each aligned row: push {row, captured_cnt} if not full, else set
//               overflow. captured_cnt increments either way.
//             - captured_cnt reaches num_rows -> DRAIN.
//     DRAIN   - aligned rows ignored.
//             - FIFO empty after the final pop -> done pulse, then IDLE.
//   start while busy is ignored. num_rows is held from its latch until IDLE.
//   Full FIFO with pop and push in the same cycle: both succeed, no overflow.
//   Empty FIFO: out_valid=0, out_data holds its last value.
//   Read/write pointers wrap modulo FIFO_DEPTH; one extra bit separates full from empty.
//   Mid-operation rst_n low: immediate return to reset state; buffered rows lost.
//   Sums are treated as signed two's complement; no width change.
// CONFIGURATION
//   SYSARR_COLLECT_RELU_EN defined: each lane is passed through ReLU on FIFO write
//     (sum[15]==1 -> 16'h0000); flags and latency unchanged.
//   Not defined: sums stored and emitted unmodified.
// TESTING
//   1 W=2, start num_rows=2; colvalid skewed, rows {c0=3,c1=5},{c0=7,c1=-2}
//     -> out rows 0,1 = {3,5},{7,16'hFFFE}; done 1 cycle after the second handshake.
//   2 out_ready=0, num_rows=6, DEPTH=4 -> 4 rows buffered, overflow=1; release
//     ready -> rows 0..3 emitted, done pulses, overflow stays 1 until next start.
//   3 colvalid=2'b01 with no column-1 follow-up -> skew_err=1, nothing pushed,
//     captured count unchanged.
//   4 FIFO full, ready=1, new aligned row in the same cycle -> no overflow,
//     count stays 4, row order preserved.
//   5 rst_n low during COLLECT with 2 rows buffered -> out_valid=0, busy=0 at once;
//     start num_rows=0 -> done next cycle, busy never set.
//   6 RELU_EN build, row {-1,9} -> out {0,9}; non-RELU build -> {16'hFFFF,9}.

Source files
------------

// File: rtl/sys_arr_result_collector.sv
// Deskews the systolic array's column-skewed bottom-row sums into whole rows and
// buffers them in a FIFO for a valid/ready consumer. Optional macro: SYSARR_COLLECT_RELU_EN.
module sys_arr_result_collector #(
    parameter int WIDTH_HEIGHT = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                num_rows,
    input  logic [16*WIDTH_HEIGHT-1:0] maccin,
    input  logic [WIDTH_HEIGHT-1:0]   colvalid,
    output logic [16*WIDTH_HEIGHT-1:0] out_data,
    output logic [7:0]                out_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      skew_err,
    output logic [1:0]                fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 16 * WIDTH_HEIGHT;
    localparam int EW = DW + 8;
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    // Stream contract: a row transfers on every cycle where out_valid && out_ready;
    // out_valid never depends on out_ready, and data/row stay stable until taken.

    logic [15:0]             al_lane [WIDTH_HEIGHT];
    logic [WIDTH_HEIGHT-1:0] al_valid;
    logic [DW-1:0]           al_row;
    logic                    aligned;
    logic                    partial;

    // Column j is delayed WIDTH_HEIGHT-1-j cycles so all lanes line up with the last one.
    for (genvar j = 0; j < WIDTH_HEIGHT; j++) begin : g_col
        localparam int STAGES = WIDTH_HEIGHT - 1 - j;
        if (STAGES == 0) begin : g_direct
            assign al_lane[j]  = maccin[16*j +: 16];
            assign al_valid[j] = colvalid[j];
        end else begin : g_delay
            logic [15:0]       sd [STAGES];
            logic [STAGES-1:0] sv;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < STAGES; k++) sd[k] <= '0;
                    sv <= '0;
                end else begin
                    sd[0] <= maccin[16*j +: 16];
                    sv[0] <= colvalid[j];
                    for (int k = 1; k < STAGES; k++) begin
                        sd[k] <= sd[k-1];
                        sv[k] <= sv[k-1];
                    end
                end
            end
            assign al_lane[j]  = sd[STAGES-1];
            assign al_valid[j] = sv[STAGES-1];
        end
    end

    always_comb begin
        al_row = '0;
        for (int i = 0; i < WIDTH_HEIGHT; i++) al_row[16*i +: 16] = al_lane[i];
    end

    assign aligned = &al_valid;
    assign partial = (|al_valid) && !aligned;

    function automatic logic [DW-1:0] lane_fix(input logic [DW-1:0] r);
        logic [DW-1:0] v;
        v = r;
`ifdef SYSARR_COLLECT_RELU_EN
        for (int i = 0; i < WIDTH_HEIGHT; i++)
            if (r[16*i+15]) v[16*i +: 16] = 16'h0000;
`endif
        return v;
    endfunction

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, fifo_cnt;
    logic [EW-1:0] head, last_q;
    logic          empty, full, push, pop;
    logic [1:0]    state;
    logic [7:0]    captured_cnt, rows_q;

    assign fifo_cnt  = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push      = (state == S_COLLECT) && aligned && (!full || pop);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;
    assign out_data  = empty ? last_q[DW-1:0] : head[DW-1:0];
    assign out_row   = empty ? last_q[EW-1:DW] : head[EW-1:DW];
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {captured_cnt, lane_fix(al_row)};
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                last_q <= head;
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            captured_cnt <= '0;
            rows_q       <= '0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            skew_err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (partial) skew_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start && num_rows != 8'd0) begin
                        rows_q       <= num_rows;
                        captured_cnt <= '0;
                        overflow     <= 1'b0;
                        skew_err     <= 1'b0;
                        state        <= S_COLLECT;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (aligned) begin
                        if (full && !pop) overflow <= 1'b1;
                        captured_cnt <= captured_cnt + 8'd1;
                        if (captured_cnt + 8'd1 == rows_q) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (empty || (pop && fifo_cnt == PTR_ONE)) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_arr_result_collector.sv
// Scoreboard bench for sys_arr_result_collector (WIDTH_HEIGHT=2, FIFO_DEPTH=4),
// checked against a row-level reference model; honours SYSARR_COLLECT_RELU_EN.
module tb_sys_arr_result_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_rows = 8'd0;
    logic [31:0] maccin = 32'd0;
    logic [1:0]  colvalid = 2'b00;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [7:0]  out_row;
    logic        out_valid, busy, done, overflow, skew_err;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad = 0;
    bit rand_rdy = 0;

    sys_arr_result_collector #(.WIDTH_HEIGHT(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
        .maccin(maccin), .colvalid(colvalid), .out_data(out_data),
        .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow), .skew_err(skew_err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [39:0] exp_q[$];
    int          m_phase;   // 0 idle, 1 collecting, 2 draining
    int          m_cnt, m_nr;
    bit          m_ovf, m_skew, m_done;
    bit          prev_v0;
    logic [15:0] prev_d0;
    bit          m_aligned, m_partial, m_nd;

    function automatic logic [15:0] lane(input logic [15:0] v);
`ifdef SYSARR_COLLECT_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_phase = 0; m_cnt = 0; m_nr = 0;
            m_ovf = 0; m_skew = 0; m_done = 0;
            prev_v0 = 0; prev_d0 = '0;
        end else begin
            // A row is whole when column 0 was valid last cycle and column 1 is valid now.
            m_aligned = prev_v0 && colvalid[1];
            m_partial = prev_v0 != colvalid[1];
            m_nd = 0;
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (m_partial) m_skew = 1;
            if (m_phase == 0) begin
                if (start && num_rows == 0) m_nd = 1;
                else if (start) begin
                    m_phase = 1; m_nr = num_rows; m_cnt = 0; m_ovf = 0; m_skew = 0;
                end
            end else if (m_phase == 1) begin
                if (m_aligned) begin
                    if (exp_q.size() < 4)
                        exp_q.push_back({8'(m_cnt), lane(maccin[31:16]), lane(prev_d0)});
                    else
                        m_ovf = 1;
                    m_cnt++;
                    if (m_cnt == m_nr) m_phase = 2;
                end
            end else begin
                if (exp_q.size() == 0) begin
                    m_nd = 1; m_phase = 0;
                end
            end
            prev_v0 = colvalid[0];
            prev_d0 = maccin[15:0];
            m_done = m_nd;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (out_valid && exp_q.size() != 0) check("row_entry", 64'({out_row, out_data}), 64'(exp_q[0]));
        check("busy", 64'(busy), 64'(m_phase != 0));
        check("done", 64'(done), 64'(m_done));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("skew_err", 64'(skew_err), 64'(m_skew));
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_rows = 8'(n);
        tick();
        start = 1'b0;
        num_rows = 8'($urandom_range(0, 255));
    endtask

    logic [15:0] r0[$], r1[$];

    // Drives the queued rows back-to-back with the column-1 lane one cycle behind column 0.
    task automatic send_rows();
        int n;
        n = r0.size();
        for (int i = 0; i <= n; i++) begin
            colvalid[0] = (i < n);
            colvalid[1] = (i >= 1);
            maccin[15:0]  = (i < n) ? r0[i] : 16'($urandom);
            maccin[31:16] = (i >= 1) ? r1[i-1] : 16'($urandom);
            tick();
        end
        colvalid = 2'b00;
        r0.delete();
        r1.delete();
    endtask

    task automatic rand_rows(input int n);
        for (int i = 0; i < n; i++) begin
            r0.push_back(16'($urandom));
            r1.push_back(16'($urandom));
        end
        send_rows();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(m_phase == 0 && exp_q.size() == 0) && k < 300) begin
            tick();
            k++;
        end
        total++;
        if (k >= 300) begin
            bad++;
            $display("FAIL wait_idle: got timeout expected idle at %0t", $time);
        end
        repeat (2) tick();
    endtask

    initial begin
        repeat (3) tick();
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_row", 64'(out_row), 64'd0);
        rst_n = 1'b1;
        tick();

        // two-row directed transfer, one signed value
        out_ready = 1'b1;
        do_start(2);
        r0 = '{16'd3, 16'd7};
        r1 = '{16'd5, 16'hFFFE};
        send_rows();
        wait_idle();

        // consumer stalled: two of six rows are dropped
        out_ready = 1'b0;
        do_start(6);
        rand_rows(6);
        repeat (3) tick();
        check("ovf_set", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        wait_idle();
        check("ovf_sticky", 64'(overflow), 64'd1);

        // lone column-0 valid inside a collection
        do_start(2);
        colvalid = 2'b01;
        tick();
        colvalid = 2'b00;
        repeat (2) tick();
        check("skew_set", 64'(skew_err), 64'd1);
        rand_rows(2);
        wait_idle();

        // full FIFO with a pop and a push on the same edge
        out_ready = 1'b0;
        do_start(6);
        rand_rows(4);
        tick();
        colvalid = 2'b01; maccin = {16'd0, 16'h1111};
        tick();
        colvalid = 2'b10; maccin = {16'h2222, 16'd0}; out_ready = 1'b1;
        tick();
        colvalid = 2'b00;
        rand_rows(1);
        wait_idle();
        check("no_ovf_full_swap", 64'(overflow), 64'd0);

        // reset during a collection, then a zero-row start
        out_ready = 1'b0;
        do_start(5);
        rand_rows(2);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(0);
        repeat (2) tick();

        // ReLU/pass-through row {-1, 9}
        out_ready = 1'b1;
        do_start(1);
        r0 = '{16'hFFFF};
        r1 = '{16'd9};
        send_rows();
        wait_idle();

        // randomized collections with random ready and stray valids
        rand_rdy = 1;
        repeat (8) begin
            do_start($urandom_range(1, 8));
            repeat (6) begin
                if ($urandom_range(0, 5) == 0) begin
                    colvalid = 2'($urandom_range(1, 2));
                    maccin = $urandom;
                    tick();
                    colvalid = 2'b00;
                    tick();
                end else begin
                    rand_rows($urandom_range(1, 3));
                end
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_idle();
        end
        rand_rdy = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
